mem_port_arbiter: RTL and testbench

Shares the single instruction/data memory port between the instruction fetch stage and the data (load/store) stage. Arbitrates pending requests, drives a registered request onto the memory port, holds it until the memory acknowledges, and returns the acknowledge and read data to the owning requester. Sits between the pipeline's fetch/memory stages and the memory model or bus interface.

---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-port signals of the shared memory arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_flush_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [DATA_W/8-1:0] d_be_i;
    logic              d_ack_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W/8-1:0] mem_be_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;
    modport slave (
        input  if_req_i, if_addr_i, if_flush_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
               mem_ack_i, mem_rdata_i,
        output if_ack_o, if_rdata_o, d_ack_o, d_rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );
    modport master (
        output if_req_i, if_addr_i, if_flush_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
               mem_ack_i, mem_rdata_i,
        input  if_ack_o, if_rdata_o, d_ack_o, d_rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data stages; define ARB_STARVE_GUARD_EN for the fetch starvation guard
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input logic clk,
    input logic rst_i,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;
    state_t              state_q, state_d;
    logic                req_q, req_d, we_q, we_d, discard_q, discard_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] be_q, be_d;
    logic                if_want, grant_d, grant_if;

    if (STARVE_MAX < 1 || STARVE_MAX > 15 || DATA_W % 8 != 0) begin : g_bad_param
        $error("mem_port_arbiter: illegal parameter value");
    end

    assign if_want = bus.if_req_i && !bus.if_flush_i;
`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] starve_q, starve_d;
    assign grant_d = bus.d_req_i && !(if_want && starve_q == STARVE_LIM);
    // count data grants taken over a waiting fetch; any other grant restarts the count
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE && grant_d)
            starve_d = if_want ? (starve_q == STARVE_LIM ? starve_q : starve_q + 4'd1) : 4'd0;
        else if (state_q == IDLE && grant_if)
            starve_d = 4'd0;
    end
    // starvation counter register
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) starve_q <= 4'd0;
        else       starve_q <= starve_d;
    end
`else
    assign grant_d = bus.d_req_i;
`endif
    assign grant_if = if_want && !grant_d;

    // arbitrate in IDLE, latch the winner, hold it until the memory acknowledges
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        discard_d = state_q == IF_BUSY && !bus.mem_ack_i && (discard_q || bus.if_flush_i);
        if (state_q == IDLE) begin
            if (grant_d) begin
                state_d = D_BUSY;
                req_d   = 1'b1;
                we_d    = bus.d_we_i;
                addr_d  = bus.d_addr_i;
                wdata_d = bus.d_wdata_i;
                be_d    = bus.d_be_i;
            end else if (grant_if) begin
                state_d = IF_BUSY;
                req_d   = 1'b1;
                we_d    = 1'b0;
                addr_d  = bus.if_addr_i;
                wdata_d = '0;
                be_d    = '1;
            end
        end else if (bus.mem_ack_i) begin
            state_d = IDLE;
            req_d   = 1'b0;
        end
    end

    // state and registered memory request
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            discard_q <= discard_d;
        end
    end

    assign bus.mem_req_o   = req_q;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.mem_be_o    = be_q;
    assign bus.d_ack_o     = bus.mem_ack_i && state_q == D_BUSY;
    assign bus.if_ack_o    = bus.mem_ack_i && state_q == IF_BUSY && !discard_q && !bus.if_flush_i;
    assign bus.if_rdata_o  = bus.mem_rdata_i;
    assign bus.d_rdata_o   = bus.mem_rdata_i;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_port_arbiter dut (.clk(clk), .rst_i(rst_i), .bus(bus));

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } grant_t;

    grant_t      exp_grant[$];
    logic [31:0] exp_if[$];
    logic [31:0] exp_d[$];
    int          errors = 0;
    int          checks = 0;
    int          mem_lat = 2;
    int          wcnt = 0;
    logic        ack_m = 1'b0;
    logic        spur = 1'b0;
    logic        prev_req = 1'b0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return a == 32'h100 ? 32'hE3A00001 : {a[15:0], 16'hC0DE} ^ 32'h1234_0000;
    endfunction

    assign bus.mem_ack_i   = ack_m | spur;
    assign bus.mem_rdata_i = bus.mem_ack_i ? mem_val(bus.mem_addr_o) : 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no response expected one within 200 cycles", name);
    endtask

    task automatic push_grant(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        grant_t g;
        g.we = we; g.addr = a; g.wdata = wd; g.be = be;
        exp_grant.push_back(g);
    endtask

    // memory model: ack mem_lat cycles after the request appears, one cycle wide
    initial forever begin
        @(posedge clk);
        #1;
        if (bus.mem_req_o && !ack_m) begin
            if (wcnt >= mem_lat) begin ack_m = 1'b1; wcnt = 0; end
            else wcnt++;
        end else begin
            ack_m = 1'b0;
            wcnt = 0;
        end
    end

    // monitor: compare each new grant and each ack against the scoreboard
    initial forever begin
        @(negedge clk);
        if (bus.mem_req_o && !prev_req) begin
            if (exp_grant.size() == 0) begin
                tmo("unexpected_grant");
            end else begin
                grant_t g;
                g = exp_grant.pop_front();
                chk("grant_we", bus.mem_we_o, g.we);
                chk("grant_addr", bus.mem_addr_o, g.addr);
                chk("grant_wdata", bus.mem_wdata_o, g.wdata);
                chk("grant_be", bus.mem_be_o, g.be);
            end
        end
        prev_req = bus.mem_req_o;
        if (bus.if_ack_o) begin
            if (exp_if.size() == 0) chk("unexpected_if_ack", bus.if_ack_o, 1'b0);
            else chk("if_rdata", bus.if_rdata_o, exp_if.pop_front());
        end
        if (bus.d_ack_o) begin
            if (exp_d.size() == 0) chk("unexpected_d_ack", bus.d_ack_o, 1'b0);
            else chk("d_rdata", bus.d_rdata_o, exp_d.pop_front());
        end
    end

    task automatic wait_mem_req();
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mem_req_o;
        end
        if (!seen) tmo("mem_req_wait");
    endtask

    task automatic fetch(input logic [31:0] a);
        bit done = 0;
        bus.if_req_i = 1'b1;
        bus.if_addr_i = a;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = bus.if_ack_o;
        end
        if (!done) tmo("fetch_ack_wait");
        @(posedge clk);
        #1;
        bus.if_req_i = 1'b0;
    endtask

    task automatic data(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be, input int n);
        for (int k = 0; k < n; k++) begin
            bit done = 0;
            bus.d_req_i = 1'b1;
            bus.d_we_i = we;
            bus.d_addr_i = a + 32'(4 * k);
            bus.d_wdata_i = wd;
            bus.d_be_i = be;
            for (int i = 0; i < 200 && !done; i++) begin
                @(negedge clk);
                done = bus.d_ack_o;
            end
            if (!done) tmo("data_ack_wait");
            @(posedge clk);
            #1;
        end
        bus.d_req_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.if_req_i = 0; bus.if_addr_i = 0; bus.if_flush_i = 0;
        bus.d_req_i = 0; bus.d_we_i = 0; bus.d_addr_i = 0; bus.d_wdata_i = 0; bus.d_be_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", bus.mem_req_o, 1'b0);
        chk("rst_mem_we", bus.mem_we_o, 1'b0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
        chk("rst_mem_be", bus.mem_be_o, 4'h0);
        chk("rst_if_ack", bus.if_ack_o, 1'b0);
        chk("rst_d_ack", bus.d_ack_o, 1'b0);
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        mem_lat = 2;
        push_grant(1'b0, 32'h100, 32'h0, 4'hF);
        exp_if.push_back(32'hE3A00001);
        fetch(32'h100);

        mem_lat = 1;
        push_grant(1'b1, 32'h1000, 32'hDEADBEEF, 4'h3);
        push_grant(1'b0, 32'h200, 32'h0, 4'hF);
        exp_d.push_back(mem_val(32'h1000));
        exp_if.push_back(mem_val(32'h200));
        fork
            fetch(32'h200);
            data(1'b1, 32'h1000, 32'hDEADBEEF, 4'h3, 1);
        join

        mem_lat = 0;
`ifdef ARB_STARVE_GUARD_EN
        for (int k = 0; k < 4; k++) push_grant(1'b0, 32'h2000 + 32'(4 * k), 32'h0, 4'hF);
        push_grant(1'b0, 32'h500, 32'h0, 4'hF);
        for (int k = 4; k < 6; k++) push_grant(1'b0, 32'h2000 + 32'(4 * k), 32'h0, 4'hF);
`else
        for (int k = 0; k < 6; k++) push_grant(1'b0, 32'h2000 + 32'(4 * k), 32'h0, 4'hF);
        push_grant(1'b0, 32'h500, 32'h0, 4'hF);
`endif
        for (int k = 0; k < 6; k++) exp_d.push_back(mem_val(32'h2000 + 32'(4 * k)));
        exp_if.push_back(mem_val(32'h500));
        fork
            fetch(32'h500);
            data(1'b0, 32'h2000, 32'h0, 4'hF, 6);
        join

        mem_lat = 3;
        push_grant(1'b0, 32'h300, 32'h0, 4'hF);
        push_grant(1'b0, 32'h400, 32'h0, 4'hF);
        exp_if.push_back(mem_val(32'h400));
        bus.if_req_i = 1'b1;
        bus.if_addr_i = 32'h300;
        wait_mem_req();
        @(posedge clk);
        #1;
        bus.if_flush_i = 1'b1;
        bus.if_req_i = 1'b0;
        @(posedge clk);
        #1;
        bus.if_flush_i = 1'b0;
        chk("flush_req_held", bus.mem_req_o, 1'b1);
        fetch(32'h400);

        mem_lat = 1;
        push_grant(1'b0, 32'h600, 32'h0, 4'hF);
        bus.if_req_i = 1'b1;
        bus.if_addr_i = 32'h600;
        wait_mem_req();
        @(posedge clk);
        #1;
        bus.if_flush_i = 1'b1;
        bus.if_req_i = 1'b0;
        @(negedge clk);
        chk("flush_with_ack_if_ack", bus.if_ack_o, 1'b0);
        @(posedge clk);
        #1;
        bus.if_flush_i = 1'b0;

        bus.if_req_i = 1'b1;
        bus.if_addr_i = 32'h700;
        bus.if_flush_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("flush_idle_no_grant", bus.mem_req_o, 1'b0);
        end
        @(posedge clk);
        #1;
        bus.if_req_i = 1'b0;
        bus.if_flush_i = 1'b0;

        mem_lat = 5;
        push_grant(1'b0, 32'h40, 32'h0, 4'hF);
        push_grant(1'b0, 32'h40, 32'h0, 4'hF);
        exp_d.push_back(mem_val(32'h40));
        bus.d_req_i = 1'b1;
        bus.d_we_i = 1'b0;
        bus.d_addr_i = 32'h40;
        bus.d_wdata_i = 32'h0;
        bus.d_be_i = 4'hF;
        wait_mem_req();
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        #1;
        chk("busy_rst_mem_req", bus.mem_req_o, 1'b0);
        chk("busy_rst_mem_addr", bus.mem_addr_o, 32'h0);
        chk("busy_rst_mem_be", bus.mem_be_o, 4'h0);
        chk("busy_rst_d_ack", bus.d_ack_o, 1'b0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        data(1'b0, 32'h40, 32'h0, 4'hF, 1);

        @(posedge clk);
        #1;
        spur = 1'b1;
        @(negedge clk);
        chk("spur_if_ack", bus.if_ack_o, 1'b0);
        chk("spur_d_ack", bus.d_ack_o, 1'b0);
        @(posedge clk);
        #1;
        spur = 1'b0;
        @(negedge clk);
        chk("spur_no_req", bus.mem_req_o, 1'b0);
        mem_lat = 2;
        push_grant(1'b0, 32'h800, 32'h0, 4'hF);
        exp_if.push_back(mem_val(32'h800));
        fetch(32'h800);

        repeat (3) @(posedge clk);
        chk("grant_queue_drained", 32'(exp_grant.size()), 32'h0);
        chk("if_queue_drained", 32'(exp_if.size()), 32'h0);
        chk("d_queue_drained", 32'(exp_d.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
